// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
//
// ID/EX issue stage. Takes decoded ops from decode over a valid/ready
// handshake, resolves rs1/rs2 through the MEM/WB bypass paths, picks the
// immediate or rs2 as operand B, and presents the op on registered alu_*
// ports. A two-entry buffer (main + skid) lets dec_ready stay a register
// while execute applies backpressure through ex_ready.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   flush                 synchronous kill of every held op
//   dec_valid/dec_ready   decode handshake (dec_ready is registered)
//   dec_alu_sel           ALU op select
//   dec_shift_amt         shift amount
//   dec_rs1/rs2_addr      source register indices
//   dec_rs1/rs2_data      register file values for the sources
//   dec_imm, dec_use_imm  sign-extended immediate, selects it as operand B
//   dec_rd_addr/rd_we     destination index and write enable
//   mem_rd_we/addr/data   MEM-stage writeback bypass
//   wb_rd_we/addr/data    WB-stage writeback bypass
//   ex_ready              execute consumes the op on alu_*
//   alu_enable            an op is valid on alu_*
//   alu_sel, alu_shift_amt, alu_data_in_a, alu_data_in_b   registered op
//   ex_rd_addr, ex_rd_we  destination of the issued op
// -----------------------------------------------------------------------------
module alu_issue_stage #(
    parameter int SEL_SIZE   = 4,
    parameter int SHIFT_SIZE = 5,
    parameter int XLEN       = 64,
    parameter int REG_ADDR   = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  dec_valid,
    output logic                  dec_ready,
    input  logic [SEL_SIZE-1:0]   dec_alu_sel,
    input  logic [SHIFT_SIZE-1:0] dec_shift_amt,
    input  logic [REG_ADDR-1:0]   dec_rs1_addr,
    input  logic [REG_ADDR-1:0]   dec_rs2_addr,
    input  logic [XLEN-1:0]       dec_rs1_data,
    input  logic [XLEN-1:0]       dec_rs2_data,
    input  logic [XLEN-1:0]       dec_imm,
    input  logic                  dec_use_imm,
    input  logic [REG_ADDR-1:0]   dec_rd_addr,
    input  logic                  dec_rd_we,
    input  logic                  mem_rd_we,
    input  logic [REG_ADDR-1:0]   mem_rd_addr,
    input  logic [XLEN-1:0]       mem_rd_data,
    input  logic                  wb_rd_we,
    input  logic [REG_ADDR-1:0]   wb_rd_addr,
    input  logic [XLEN-1:0]       wb_rd_data,
    input  logic                  ex_ready,
    output logic                  alu_enable,
    output logic [SEL_SIZE-1:0]   alu_sel,
    output logic [SHIFT_SIZE-1:0] alu_shift_amt,
    output logic [XLEN-1:0]       alu_data_in_a,
    output logic [XLEN-1:0]       alu_data_in_b,
    output logic [REG_ADDR-1:0]   ex_rd_addr,
    output logic                  ex_rd_we
);

    // Occupancy of the main/skid pair.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    // One held op. Operand B is stored already muxed (imm or rs2), so the
    // source addresses and use_imm are kept only to drive snooping.
    typedef struct packed {
        logic [SEL_SIZE-1:0]   sel;
        logic [SHIFT_SIZE-1:0] shamt;
        logic [REG_ADDR-1:0]   rs1_addr;
        logic [REG_ADDR-1:0]   rs2_addr;
        logic                  use_imm;
        logic [XLEN-1:0]       a;
        logic [XLEN-1:0]       b;
        logic [REG_ADDR-1:0]   rd_addr;
        logic                  rd_we;
    } entry_t;

    state_t state_q;
    entry_t main_q, skid_q;
    entry_t new_entry, main_snoop, skid_snoop;
    logic   dec_ready_q, enable_q;
    logic   accept, consume;

    // Bypass resolution for one source: x0 is never forwarded, and MEM is
    // younger than WB so it wins when both write the same register.
    function automatic logic [XLEN-1:0] bypass(input logic [REG_ADDR-1:0] addr,
                                               input logic [XLEN-1:0]     base);
        logic [XLEN-1:0] res;
        res = base;
        if (addr == '0) begin
            res = '0;
        end else if (mem_rd_we && (mem_rd_addr == addr)) begin
            res = mem_rd_data;
        end else if (wb_rd_we && (wb_rd_addr == addr)) begin
            res = wb_rd_data;
        end
        return res;
    endfunction

    assign accept  = dec_valid & dec_ready_q;
    assign consume = enable_q & ex_ready;

    // Build the incoming entry with bypassed operands, and refreshed copies of
    // both held entries. Held ops keep watching MEM/WB so an op that waits
    // behind backpressure never issues with a stale operand. An immediate
    // operand B is not a register value and is left alone.
    always_comb begin
        new_entry          = '0;
        new_entry.sel      = dec_alu_sel;
        new_entry.shamt    = dec_shift_amt;
        new_entry.rs1_addr = dec_rs1_addr;
        new_entry.rs2_addr = dec_rs2_addr;
        new_entry.use_imm  = dec_use_imm;
        new_entry.a        = bypass(dec_rs1_addr, dec_rs1_data);
        new_entry.b        = dec_use_imm ? dec_imm : bypass(dec_rs2_addr, dec_rs2_data);
        new_entry.rd_addr  = dec_rd_addr;
        new_entry.rd_we    = dec_rd_we;

        main_snoop   = main_q;
        main_snoop.a = bypass(main_q.rs1_addr, main_q.a);
        if (!main_q.use_imm) begin
            main_snoop.b = bypass(main_q.rs2_addr, main_q.b);
        end

        skid_snoop   = skid_q;
        skid_snoop.a = bypass(skid_q.rs1_addr, skid_q.a);
        if (!skid_q.use_imm) begin
            skid_snoop.b = bypass(skid_q.rs2_addr, skid_q.b);
        end
    end

    // Occupancy FSM with the main/skid storage. dec_ready and alu_enable are
    // written alongside every state change so they always describe the
    // state being entered. Flush empties the buffer and drops any beat
    // accepted in the same cycle; data registers keep their last values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            dec_ready_q <= 1'b1;
            enable_q    <= 1'b0;
            main_q      <= '0;
            skid_q      <= '0;
        end else if (flush) begin
            state_q     <= EMPTY;
            dec_ready_q <= 1'b1;
            enable_q    <= 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_q   <= new_entry;
                        state_q  <= FULL;
                        enable_q <= 1'b1;
                    end
                end
                FULL: begin
                    if (accept && consume) begin
                        main_q <= new_entry;
                    end else if (accept) begin
                        main_q      <= main_snoop;
                        skid_q      <= new_entry;
                        state_q     <= SKID;
                        dec_ready_q <= 1'b0;
                    end else if (consume) begin
                        state_q  <= EMPTY;
                        enable_q <= 1'b0;
                    end else begin
                        main_q <= main_snoop;
                    end
                end
                SKID: begin
                    if (consume) begin
                        main_q      <= skid_snoop;
                        state_q     <= FULL;
                        dec_ready_q <= 1'b1;
                    end else begin
                        main_q <= main_snoop;
                        skid_q <= skid_snoop;
                    end
                end
                default: begin
                    state_q     <= EMPTY;
                    dec_ready_q <= 1'b1;
                    enable_q    <= 1'b0;
                end
            endcase
        end
    end

    assign dec_ready     = dec_ready_q;
    assign alu_enable    = enable_q;
    assign alu_sel       = main_q.sel;
    assign alu_shift_amt = main_q.shamt;
    assign alu_data_in_a = main_q.a;
    assign alu_data_in_b = main_q.b;
    assign ex_rd_addr    = main_q.rd_addr;
    assign ex_rd_we      = main_q.rd_we;

endmodule

// File: tb/tb_alu_issue_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_stage
//
// Scoreboard bench for alu_issue_stage. The reference model is an ordered
// queue of up to two pending ops; each ops operands are resolved and
// refreshed from the MEM/WB bypass rules. When the model sees an op
// consumed it pushes it to the expected queue, and an independent monitor
// pops and compares whenever the DUT hands an op to execute.
// -----------------------------------------------------------------------------
module tb_alu_issue_stage;

    logic        clk, rst_n, flush;
    logic        dec_valid, dec_ready;
    logic [3:0]  dec_alu_sel;
    logic [4:0]  dec_shift_amt;
    logic [4:0]  dec_rs1_addr, dec_rs2_addr;
    logic [63:0] dec_rs1_data, dec_rs2_data, dec_imm;
    logic        dec_use_imm;
    logic [4:0]  dec_rd_addr;
    logic        dec_rd_we;
    logic        mem_rd_we, wb_rd_we;
    logic [4:0]  mem_rd_addr, wb_rd_addr;
    logic [63:0] mem_rd_data, wb_rd_data;
    logic        ex_ready;
    logic        alu_enable;
    logic [3:0]  alu_sel;
    logic [4:0]  alu_shift_amt;
    logic [63:0] alu_data_in_a, alu_data_in_b;
    logic [4:0]  ex_rd_addr;
    logic        ex_rd_we;

    typedef struct {
        logic [3:0]  sel;
        logic [4:0]  shamt;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        use_imm;
        logic [63:0] imm;
        logic [63:0] a;
        logic [63:0] rs2v;
        logic [4:0]  rd;
        logic        we;
    } op_t;

    op_t held[$];
    op_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;

    alu_issue_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_alu_sel(dec_alu_sel), .dec_shift_amt(dec_shift_amt),
        .dec_rs1_addr(dec_rs1_addr), .dec_rs2_addr(dec_rs2_addr),
        .dec_rs1_data(dec_rs1_data), .dec_rs2_data(dec_rs2_data),
        .dec_imm(dec_imm), .dec_use_imm(dec_use_imm),
        .dec_rd_addr(dec_rd_addr), .dec_rd_we(dec_rd_we),
        .mem_rd_we(mem_rd_we), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .wb_rd_we(wb_rd_we), .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data),
        .ex_ready(ex_ready),
        .alu_enable(alu_enable), .alu_sel(alu_sel), .alu_shift_amt(alu_shift_amt),
        .alu_data_in_a(alu_data_in_a), .alu_data_in_b(alu_data_in_b),
        .ex_rd_addr(ex_rd_addr), .ex_rd_we(ex_rd_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Value a register read sees this cycle: x0 is zero, otherwise the
    // youngest in-flight writer (MEM, then WB), otherwise the given value.
    function automatic logic [63:0] fwd(input logic [4:0] addr, input logic [63:0] base);
        if (addr == 5'd0) return 64'd0;
        if (mem_rd_we && mem_rd_addr == addr) return mem_rd_data;
        if (wb_rd_we && wb_rd_addr == addr) return wb_rd_data;
        return base;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // One clock edge of the reference model: the consumed op leaves in order,
    // survivors see this cycles writebacks, then an accepted op joins.
    task automatic modelStep();
        bit  cons, acc;
        op_t t;
        cons = (held.size() > 0) && ex_ready;
        acc  = dec_valid && (held.size() < 2);
        if (flush) begin
            held.delete();
            return;
        end
        if (cons) exp_q.push_back(held.pop_front());
        for (int i = 0; i < held.size(); i++) begin
            t      = held[i];
            t.a    = fwd(t.rs1, t.a);
            t.rs2v = fwd(t.rs2, t.rs2v);
            held[i] = t;
        end
        if (acc) begin
            t.sel     = dec_alu_sel;
            t.shamt   = dec_shift_amt;
            t.rs1     = dec_rs1_addr;
            t.rs2     = dec_rs2_addr;
            t.use_imm = dec_use_imm;
            t.imm     = dec_imm;
            t.a       = fwd(dec_rs1_addr, dec_rs1_data);
            t.rs2v    = fwd(dec_rs2_addr, dec_rs2_data);
            t.rd      = dec_rd_addr;
            t.we      = dec_rd_we;
            held.push_back(t);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) held.delete();
        else modelStep();
    end

    // Monitor: checks handshake outputs against model occupancy each cycle
    // and compares every op the DUT hands to execute with the expected queue.
    always begin
        logic [63:0] cap_a, cap_b;
        logic [14:0] cap_ctl;
        op_t e;
        @(negedge clk);
        #2;
        if (rst_n === 1'b1) begin
            checkOutput("alu_enable", {63'd0, alu_enable}, {63'd0, held.size() > 0});
            checkOutput("dec_ready", {63'd0, dec_ready}, {63'd0, held.size() < 2});
            if (alu_enable && ex_ready && !flush) begin
                cap_a   = alu_data_in_a;
                cap_b   = alu_data_in_b;
                cap_ctl = {alu_sel, alu_shift_amt, ex_rd_addr, ex_rd_we};
                @(posedge clk);
                #1;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL issue_unexpected actual=op a=0x%0h expected=none at %0t", cap_a, $time);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("issue_a", cap_a, e.a);
                    checkOutput("issue_b", cap_b, e.use_imm ? e.imm : e.rs2v);
                    checkOutput("issue_ctl", {49'd0, cap_ctl}, {49'd0, e.sel, e.shamt, e.rd, e.we});
                end
            end
        end
    end

    task automatic setOp(input logic [3:0] sel, input logic [4:0] rs1, input logic [63:0] d1,
                         input logic [4:0] rs2, input logic [63:0] d2,
                         input logic use_imm, input logic [63:0] imm, input logic [4:0] rd);
        dec_alu_sel   = sel;
        dec_shift_amt = 5'd3;
        dec_rs1_addr  = rs1;
        dec_rs1_data  = d1;
        dec_rs2_addr  = rs2;
        dec_rs2_data  = d2;
        dec_use_imm   = use_imm;
        dec_imm       = imm;
        dec_rd_addr   = rd;
        dec_rd_we     = 1'b1;
    endtask

    task automatic setBypass(input logic mwe, input logic [4:0] ma, input logic [63:0] md,
                             input logic wwe, input logic [4:0] wa, input logic [63:0] wd);
        mem_rd_we   = mwe;
        mem_rd_addr = ma;
        mem_rd_data = md;
        wb_rd_we    = wwe;
        wb_rd_addr  = wa;
        wb_rd_data  = wd;
    endtask

    // Called at a falling edge: drives the control inputs for one cycle and
    // returns at the next falling edge.
    task automatic applyStimulus(input logic valid, input logic ready, input logic fl);
        dec_valid = valid;
        ex_ready  = ready;
        flush     = fl;
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        setOp(4'd0, 5'd0, 64'd0, 5'd0, 64'd0, 1'b0, 64'd0, 5'd0);
        dec_rd_we = 1'b0;
        setBypass(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        dec_valid = 1'b0;
        ex_ready  = 1'b0;
        flush     = 1'b0;
        repeat (3) @(negedge clk);
        $display("[TB] reset state");
        checkOutput("rst_enable", {63'd0, alu_enable}, 64'd0);
        checkOutput("rst_ready", {63'd0, dec_ready}, 64'd1);
        checkOutput("rst_a", alu_data_in_a, 64'd0);
        checkOutput("rst_b", alu_data_in_b, 64'd0);
        checkOutput("rst_we", {63'd0, ex_rd_we}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] basic issue");
        setOp(4'd1, 5'd3, 64'd5, 5'd4, 64'd7, 1'b0, 64'd0, 5'd5);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("t1_enable", {63'd0, alu_enable}, 64'd1);
        checkOutput("t1_a", alu_data_in_a, 64'd5);
        checkOutput("t1_b", alu_data_in_b, 64'd7);
        checkOutput("t1_sel", {60'd0, alu_sel}, 64'd1);
        applyStimulus(1'b0, 1'b1, 1'b0);

        $display("[TB] MEM beats WB");
        setBypass(1'b1, 5'd3, 64'hAA, 1'b1, 5'd3, 64'hBB);
        setOp(4'd2, 5'd3, 64'd1, 5'd0, 64'd9, 1'b0, 64'd0, 5'd6);
        applyStimulus(1'b1, 1'b0, 1'b0);
        setBypass(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        checkOutput("t2_a", alu_data_in_a, 64'hAA);
        checkOutput("t2_b_x0", alu_data_in_b, 64'd0);
        applyStimulus(1'b0, 1'b1, 1'b0);

        $display("[TB] skid fill and drain");
        setOp(4'd3, 5'd1, 64'd11, 5'd2, 64'd22, 1'b0, 64'd0, 5'd7);
        applyStimulus(1'b1, 1'b0, 1'b0);
        setOp(4'd4, 5'd5, 64'd33, 5'd6, 64'd44, 1'b0, 64'd0, 5'd8);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("t3_skid_ready", {63'd0, dec_ready}, 64'd0);
        checkOutput("t3_first_a", alu_data_in_a, 64'd11);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("t3_second_a", alu_data_in_a, 64'd33);
        checkOutput("t3_ready_back", {63'd0, dec_ready}, 64'd1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("t3_empty", {63'd0, alu_enable}, 64'd0);

        $display("[TB] skid snoop");
        for (int k = 0; k < 2; k++) begin
            setOp(4'd5, 5'd1, 64'd1, 5'd2, 64'd2, 1'b0, 64'd0, 5'd9);
            applyStimulus(1'b1, 1'b0, 1'b0);
            setOp(4'd6, 5'd8, 64'h10, 5'd9, 64'd1, k[0], 64'hFFFF_FFFF_FFFF_FFFC, 5'd10);
            applyStimulus(1'b1, 1'b0, 1'b0);
            setBypass(1'b0, 5'd0, 64'd0, 1'b1, 5'd9, 64'd42);
            applyStimulus(1'b0, 1'b0, 1'b0);
            setBypass(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
            applyStimulus(1'b0, 1'b1, 1'b0);
            checkOutput(k == 0 ? "t4_b_snooped" : "t4_b_imm", alu_data_in_b,
                        k == 0 ? 64'd42 : 64'hFFFF_FFFF_FFFF_FFFC);
            applyStimulus(1'b0, 1'b1, 1'b0);
        end

        $display("[TB] x0 never forwarded");
        setBypass(1'b1, 5'd0, 64'h55, 1'b0, 5'd0, 64'd0);
        setOp(4'd7, 5'd0, 64'h77, 5'd2, 64'd3, 1'b0, 64'd0, 5'd11);
        applyStimulus(1'b1, 1'b0, 1'b0);
        setBypass(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        checkOutput("t5_a_x0", alu_data_in_a, 64'd0);
        applyStimulus(1'b0, 1'b1, 1'b0);

        $display("[TB] flush in skid");
        setOp(4'd8, 5'd1, 64'd1, 5'd2, 64'd2, 1'b0, 64'd0, 5'd12);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("t6_flush_enable", {63'd0, alu_enable}, 64'd0);
        checkOutput("t6_flush_ready", {63'd0, dec_ready}, 64'd1);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("t6_flush_no_issue", {63'd0, alu_enable}, 64'd0);

        $display("[TB] async reset in skid");
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_enable", {63'd0, alu_enable}, 64'd0);
        checkOutput("t6_rst_ready", {63'd0, dec_ready}, 64'd1);
        checkOutput("t6_rst_a", alu_data_in_a, 64'd0);
        checkOutput("t6_rst_rd", {59'd0, ex_rd_addr}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("t6_no_replay", {63'd0, alu_enable}, 64'd0);

        $display("[TB] random traffic");
        for (int n = 0; n < 3000; n++) begin
            setOp(4'($urandom_range(0, 15)), 5'($urandom_range(0, 7)), {$urandom, $urandom},
                  5'($urandom_range(0, 7)), {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                  {$urandom, $urandom}, 5'($urandom_range(0, 31)));
            dec_shift_amt = 5'($urandom_range(0, 31));
            dec_rd_we     = 1'($urandom_range(0, 1));
            setBypass(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), {$urandom, $urandom},
                      1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), {$urandom, $urandom});
            applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                          $urandom_range(0, 99) < 3);
        end

        setBypass(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
        repeat (4) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("drain_enable", {63'd0, alu_enable}, 64'd0);
        checkOutput("drain_pending", exp_q.size(), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
